onebit_tone_rx: RTL and testbench

Receive-side counterpart of the 1-bit two-tone DDS transmitter. Samples a 1-bit RF/IF input and mixes it against a quadrature square-wave local oscillator from a 32-bit phase accumulator. I/Q products are integrated over fixed windows, and the block emits one |I|+|Q| magnitude per window over a req/ack stream, plus a tone-detect flag. Sits between the board RF input pin and downstream logging/decode logic.

---
 rtl/onebit_tone_rx_pkg.sv | 18 +
 rtl/tone_rx_mixer_acc.sv | 34 +++
 rtl/onebit_tone_rx.sv | 150 +++++++++++++++
 tb/tb_onebit_tone_rx.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/onebit_tone_rx_pkg.sv
// Shared definitions for the 1-bit two-tone receiver: accumulator width
// derivation, the 1-bit product to +/-1 mapping and the phase reset value.
package onebit_tone_rx_pkg;

    // Phase accumulator value after reset.
    localparam logic [31:0] PH_RESET = 32'h0000_0000;

    // Signed accumulator width: holds +/-dump_len with one bit of headroom.
    function automatic int acc_w_f(input int dump_len);
        return $clog2(dump_len) + 2;
    endfunction

    // Mixer product bit to a signed step: 1 -> +1, 0 -> -1.
    function automatic logic signed [1:0] sign_pm1(input logic b);
        return b ? 2'sb01 : 2'sb11;
    endfunction

endpackage

// File: rtl/tone_rx_mixer_acc.sv
// One mixer arm: XORs the synchronized RF bit with a square-wave LO bit and
// integrates the resulting +/-1 stream. The dump strobe restarts the sum with
// the current product so windows run back to back without a bubble cycle.
module tone_rx_mixer_acc
    import onebit_tone_rx_pkg::*;
#(
    parameter int ACC_W = 14
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    rf_s,
    input  logic                    lo,
    input  logic                    dump,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [1:0]       step;
    logic signed [ACC_W-1:0] step_ext;

    assign step     = sign_pm1(rf_s ^ lo);
    assign step_ext = {{(ACC_W-2){step[1]}}, step};

    // Integrate: load on dump, otherwise add the +/-1 step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
        end else if (dump) begin
            acc <= step_ext;
        end else begin
            acc <= acc + step_ext;
        end
    end

endmodule

// File: rtl/onebit_tone_rx.sv
// 1-bit RF receiver: quadrature square-wave LO from a 32-bit phase
// accumulator, I/Q integrate-and-dump over DUMP_LEN samples, one |I|+|Q|
// magnitude per window on a req/ack stream, plus a tone-detect flag.
// Optional build macro: TONE_RX_HYST_EN adds set/clear hysteresis to tone_det.
module onebit_tone_rx
    import onebit_tone_rx_pkg::*;
#(
    parameter int DUMP_LEN = 4096,
    parameter int ACC_W    = acc_w_f(DUMP_LEN)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rf_in,
    input  logic [31:0]      cfg_inc,
    input  logic [ACC_W-1:0] cfg_thresh,
    output logic [ACC_W-1:0] m_mag_dat,
    output logic             m_mag_req,
    input  logic             m_mag_ack,
    output logic             tone_det,
    output logic             ovf
);

    localparam int               CNT_W     = $clog2(DUMP_LEN);
    localparam logic [CNT_W-1:0] WCNT_LAST = CNT_W'(DUMP_LEN - 1);

    logic                    rf_m, rf_s;
    logic [31:0]             ph, inc_l, eff_inc;
    logic [CNT_W-1:0]        wcnt;
    logic                    win_start;
    logic                    lo_i, lo_q;
    logic signed [ACC_W-1:0] acc_i, acc_q;
    logic                    last_q, res_vld;
    logic signed [ACC_W-1:0] res_i, res_q, neg_i, neg_q;
    logic [ACC_W-1:0]        abs_i, abs_q, mag;
    logic                    det_next;

    // Two-flop synchronizer for the asynchronous RF pin.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_m <= 1'b0;
            rf_s <= 1'b0;
        end else begin
            rf_m <= rf_in;
            rf_s <= rf_m;
        end
    end

    // The increment is sampled only at a window start, so a mid-window
    // cfg_inc change cannot disturb the window in progress.
    assign win_start = (wcnt == '0);
    assign eff_inc   = win_start ? cfg_inc : inc_l;

    // Phase accumulator and free-running window counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ph    <= PH_RESET;
            inc_l <= '0;
            wcnt  <= '0;
        end else begin
            ph    <= ph + eff_inc;
            inc_l <= eff_inc;
            wcnt  <= wcnt + 1'b1;
        end
    end

    // Quadrature LO: I is the top phase bit, Q leads it by a quarter turn.
    assign lo_i = ph[31];
    assign lo_q = ph[31] ^ ph[30];

    tone_rx_mixer_acc #(.ACC_W(ACC_W)) u_mix_i (
        .clk     (clk),
        .reset_n (reset_n),
        .rf_s    (rf_s),
        .lo      (lo_i),
        .dump    (win_start),
        .acc     (acc_i)
    );

    tone_rx_mixer_acc #(.ACC_W(ACC_W)) u_mix_q (
        .clk     (clk),
        .reset_n (reset_n),
        .rf_s    (rf_s),
        .lo      (lo_q),
        .dump    (win_start),
        .acc     (acc_q)
    );

    // Capture the completed window sums on the edge after the last sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q  <= 1'b0;
            res_vld <= 1'b0;
            res_i   <= '0;
            res_q   <= '0;
        end else begin
            last_q  <= (wcnt == WCNT_LAST);
            res_vld <= last_q;
            if (last_q) begin
                res_i <= acc_i;
                res_q <= acc_q;
            end
        end
    end

    // |I|+|Q|; each term is at most DUMP_LEN so the sum fits in ACC_W bits.
    assign neg_i = -res_i;
    assign neg_q = -res_q;
    assign abs_i = res_i[ACC_W-1] ? $unsigned(neg_i) : $unsigned(res_i);
    assign abs_q = res_q[ACC_W-1] ? $unsigned(neg_q) : $unsigned(res_q);
    assign mag   = abs_i + abs_q;

    // Next detect state, applied only when a new magnitude is produced.
    always_comb begin
        det_next = tone_det;
`ifdef TONE_RX_HYST_EN
        if (mag >= cfg_thresh) begin
            det_next = 1'b1;
        end else if (mag < (cfg_thresh >> 1)) begin
            det_next = 1'b0;
        end
`else
        det_next = (mag >= cfg_thresh);
`endif
    end

    // Output stream: m_mag_req is the valid, m_mag_ack the ready; a transfer
    // happens on an edge where both are high. req holds until that transfer,
    // and m_mag_dat is stable while req is high, except that a new result
    // always loads (it is never stalled): if the old one was not being
    // accepted on that edge it is overwritten and ovf pulses for one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mag_dat <= '0;
            m_mag_req <= 1'b0;
            tone_det  <= 1'b0;
            ovf       <= 1'b0;
        end else if (res_vld) begin
            m_mag_dat <= mag;
            m_mag_req <= 1'b1;
            tone_det  <= det_next;
            ovf       <= m_mag_req & ~m_mag_ack;
        end else begin
            ovf <= 1'b0;
            if (m_mag_req && m_mag_ack) begin
                m_mag_req <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_onebit_tone_rx.sv
// Bench for onebit_tone_rx: a per-window table of stimulus/expectations plus
// a timeline reference model (phase, sample delay, window sums, handshake).
// Build with +define+TONE_RX_HYST_EN to exercise the hysteresis variant.
module tb_onebit_tone_rx;

    localparam int D     = 4096;
    localparam int ACC_W = 14;
    localparam int NV    = 13;

    typedef enum int {RF_TONE, RF_CONST, RF_RAND} rf_mode_t;
    typedef enum int {ACK_HIGH, ACK_LOW, ACK_RAND, ACK_AT_LOAD, ACK_LATE} ack_mode_t;

    typedef struct {
        rf_mode_t    rf;
        int          len;
        logic [31:0] inc;
        int          thresh;
        ack_mode_t   ack;
        int          exp_mag;
        int          exp_det;
    } vec_t;

`ifdef TONE_RX_HYST_EN
    localparam int DET_2000 = 1;
`else
    localparam int DET_2000 = 0;
`endif

    logic             clk;
    logic             reset_n;
    logic             rf_in;
    logic [31:0]      cfg_inc;
    logic [ACC_W-1:0] cfg_thresh;
    logic [ACC_W-1:0] m_mag_dat;
    logic             m_mag_req;
    logic             m_mag_ack;
    logic             tone_det;
    logic             ovf;

    vec_t tab[NV];
    vec_t tab_rst;
    logic post_rst;
    int   cyc;
    int   n_chk;
    int   n_fail;

    // Reference model state
    logic [31:0]      m_ph, m_inc;
    int               m_i, m_q;
    logic             d1, d2;
    logic             m_req, m_det;
    logic [ACC_W-1:0] m_dat;
    logic [ACC_W-1:0] exp_q[$];
    int               due_q[$];
    int               win_q[$];

    onebit_tone_rx #(.DUMP_LEN(D)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rf_in      (rf_in),
        .cfg_inc    (cfg_inc),
        .cfg_thresh (cfg_thresh),
        .m_mag_dat  (m_mag_dat),
        .m_mag_req  (m_mag_req),
        .m_mag_ack  (m_mag_ack),
        .tone_det   (tone_det),
        .ovf        (ovf)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(rf_mode_t rf, int len, logic [31:0] inc, int th,
                                ack_mode_t ack, int em, int ed);
        vec_t v;
        v.rf = rf; v.len = len; v.inc = inc; v.thresh = th;
        v.ack = ack; v.exp_mag = em; v.exp_det = ed;
        return v;
    endfunction

    function automatic vec_t rec_for(int w);
        if (post_rst) return tab_rst;
        if (w >= NV) return tab[NV-1];
        return tab[w];
    endfunction

    function automatic int iabs(int x);
        return (x < 0) ? -x : x;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        cyc = 0;
        m_ph = 32'h0; m_inc = 32'h0;
        m_i = 0; m_q = 0;
        d1 = 1'b0; d2 = 1'b0;
        m_req = 1'b0; m_det = 1'b0; m_dat = '0;
        exp_q.delete(); due_q.delete(); win_q.delete();
    endtask

    // Drive one cycle, advance the model over the coming edge, then check.
    task automatic tick();
        vec_t             vr, vw, va;
        int               e, wres, since, lw;
        logic             load_edge, s, lo_i, lo_q, loaded, exp_ovf;
        logic [ACC_W-1:0] mag;
        e = cyc;
        // RF sample for cycle e reaches the accumulator two edges later.
        vr = rec_for((e + 2) / D);
        case (vr.rf)
            RF_TONE: rf_in = (((e + 2) % D) < vr.len) ? ((e % 4) < 2) : 1'b1;
            RF_RAND: rf_in = 1'($urandom_range(0, 1));
            default: rf_in = 1'b1;
        endcase
        // Only the window-start value of cfg_inc may matter.
        vw = rec_for(e / D);
        cfg_inc = ((e % D) == 0) ? vw.inc : $urandom();
        // Threshold and ack follow the result currently on the output.
        wres      = (e >= D + 1) ? (e - D - 1) / D : 0;
        since     = (e >= D + 1) ? (e - D - 1) % D : -1;
        load_edge = (since == 0);
        va = rec_for(wres);
        cfg_thresh = ACC_W'(va.thresh);
        case (va.ack)
            ACK_HIGH:    m_mag_ack = 1'b1;
            ACK_LOW:     m_mag_ack = 1'b0;
            ACK_RAND:    m_mag_ack = 1'($urandom_range(0, 1));
            ACK_AT_LOAD: m_mag_ack = load_edge;
            default:     m_mag_ack = (since >= 100);
        endcase

        // Model: sample arriving at edge e was on rf_in two edges earlier.
        s = d2; d2 = d1; d1 = rf_in;
        if ((e % D) == 0) begin
            m_inc = cfg_inc; m_i = 0; m_q = 0;
        end
        lo_i = m_ph[31];
        lo_q = m_ph[31] ^ m_ph[30];
        m_i += (s ^ lo_i) ? 1 : -1;
        m_q += (s ^ lo_q) ? 1 : -1;
        m_ph = m_ph + m_inc;
        if ((e % D) == D - 1) begin
            exp_q.push_back(ACC_W'(iabs(m_i) + iabs(m_q)));
            due_q.push_back(e + 2);
            win_q.push_back(e / D);
        end
        loaded = 1'b0; exp_ovf = 1'b0; lw = 0;
        if (due_q.size() > 0 && due_q[0] == e) begin
            void'(due_q.pop_front());
            mag = exp_q.pop_front();
            lw  = win_q.pop_front();
            exp_ovf = m_req & ~m_mag_ack;
            m_req = 1'b1;
            m_dat = mag;
`ifdef TONE_RX_HYST_EN
            if (mag >= cfg_thresh) m_det = 1'b1;
            else if (mag < (cfg_thresh >> 1)) m_det = 1'b0;
`else
            m_det = (mag >= cfg_thresh);
`endif
            loaded = 1'b1;
        end else if (m_req && m_mag_ack) begin
            m_req = 1'b0;
        end

        @(posedge clk);
        @(negedge clk);
        chk("req", m_mag_req, m_req);
        chk("ovf", ovf, exp_ovf);
        chk("tone_det", tone_det, m_det);
        if (m_req) chk("mag_dat", m_mag_dat, m_dat);
        if (loaded) begin
            va = rec_for(lw);
            if (va.exp_mag >= 0) chk("tab_mag", m_mag_dat, va.exp_mag);
            if (va.exp_det >= 0) chk("tab_det", tone_det, va.exp_det);
        end
        cyc++;
    endtask

    // Watchdog
    initial begin
        #(10 * 200000);
        n_fail++;
        $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog expired");
    end

    // Main sequence
    initial begin
        int first_req;
        n_chk = 0; n_fail = 0; post_rst = 1'b0;
        tab[0]  = mk(RF_TONE,  D,    32'h4000_0000, 3000, ACK_HIGH, -1, -1);
        tab[1]  = mk(RF_TONE,  D,    32'h4000_0000, 3000, ACK_HIGH, 4096, 1);
        tab[2]  = mk(RF_CONST, 0,    32'h4000_0000, 3000, ACK_HIGH, 0, 0);
        tab[3]  = mk(RF_TONE,  2000, 32'h4000_0000, 3000, ACK_HIGH, 2000, 0);
        tab[4]  = mk(RF_TONE,  D,    32'h4000_0000, 3000, ACK_LOW,  4096, 1);
        tab[5]  = mk(RF_TONE,  2000, 32'h4000_0000, 3000, ACK_LATE, 2000, DET_2000);
        tab[6]  = mk(RF_TONE,  1400, 32'h4000_0000, 3000, ACK_LOW,  1400, 0);
        tab[7]  = mk(RF_RAND,  0, $urandom(), $urandom_range(0, 150), ACK_AT_LOAD, -1, -1);
        tab[8]  = mk(RF_RAND,  0, $urandom(), $urandom_range(0, 150), ACK_HIGH, -1, -1);
        tab[9]  = mk(RF_RAND,  0, $urandom(), $urandom_range(0, 150), ACK_RAND, -1, -1);
        tab[10] = mk(RF_RAND,  0, $urandom(), $urandom_range(0, 150), ACK_RAND, -1, -1);
        tab[11] = mk(RF_TONE,  D,    32'h4000_0000, 3000, ACK_HIGH, 4096, 1);
        tab[12] = mk(RF_CONST, 0,    32'h4000_0000, 3000, ACK_HIGH, 0, 0);
        tab_rst = mk(RF_TONE,  D,    32'h4000_0000, 3000, ACK_HIGH, -1, -1);

        // Reset
        reset_n = 1'b0; rf_in = 1'b0; m_mag_ack = 1'b0;
        cfg_inc = 32'h0; cfg_thresh = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_dat", m_mag_dat, 0);
        chk("rst_req", m_mag_req, 0);
        chk("rst_det", tone_det, 0);
        chk("rst_ovf", ovf, 0);
        reset_n = 1'b1;

        // Table-driven windows
        for (int k = 0; k < NV * D + 2; k++) tick();

        // Mid-window reset while a result is pending
        chk("pre_rst_req", m_mag_req, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_dat", m_mag_dat, 0);
        chk("mid_rst_req", m_mag_req, 0);
        chk("mid_rst_det", tone_det, 0);
        chk("mid_rst_ovf", ovf, 0);
        repeat (3) @(negedge clk);
        post_rst = 1'b1;
        model_reset();
        reset_n = 1'b1;
        first_req = -1;
        for (int k = 0; k < 2 * D; k++) begin
            tick();
            if (first_req < 0 && m_mag_req) first_req = cyc - 1;
            if (first_req >= 0 && cyc > first_req + 3) break;
        end
        chk("rst_first_req_edge", first_req, D + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
